c2_line_sequencer: RTL and testbench
====================================

# c2_line_sequencer

Arbitrates two line-transfer requesters onto the shared cache-to-memory C2 bus (C2/D2/A2) and sequences each transfer: command beat, 8 data beats of 16 bits for a 16-byte line, response wait with watchdog, then a single-cycle completion pulse. It sits between the cache's miss/writeback logic (plus a second requester such as a dump or prefetch engine) and the memory model. Bus pins are split into out/oe/in so the top level builds the tristates.

## Interface
- `LINE_BYTES`, 16, bytes per cache line
- `BUS_W`, 16, D2 width; BEATS = LINE_BYTES*8/BUS_W = 8
- `ADDR_W`, 15, line address width (tag 10 + set 5)
- `TIMEOUT`, 255, max WAIT_RSP cycles before error completion
- `clk`  in  1  clock, all logic on rising edge
- `RESET`  in  1  asynchronous, active-low reset
- `reqN_valid`, N=0,1  in  1  transfer request
- `reqN_ready`, N=0,1  out  1  grant/accept; handshake = valid & ready
- `reqN_write`, N=0,1  in  1  1 = WRITE_LINE, 0 = READ_LINE
- `reqN_addr`, N=0,1  in  ADDR_W  line address
- `reqN_wdata`, N=0,1  in  LINE_BYTES*8  write line, byte i at bits [8i+7:8i]
- `c2_out`  out  2  command driven on C2
- `c2_oe`  out  1  C2 drive enable
- `c2_in`  in  2  sampled C2
- `a2`  out  ADDR_W  address on A2, valid in CMD only
- `d2_out`  out  BUS_W  write beat
- `d2_oe`  out  1  D2 drive enable
- `d2_in`  in  BUS_W  sampled D2
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_id`  out  1  requester index of completed transfer
- `rsp_err`  out  1  watchdog expired
- `rsp_rdata`  out  LINE_BYTES*8  read line, same byte packing as wdata
- `busy`  out  1  state != IDLE

## Operation
- Codes: C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3.
- Beat k carries line bytes 2k (D[7:0]) and 2k+1 (D[15:8]), little-endian.
- States: IDLE, CMD, WDATA, WAIT_RSP, RDATA, DONE.
- IDLE: round-robin grant. One valid requester -> granted. Both valid -> requester != last_grant. last_grant resets to 1, so requester 0 wins first tie. Only the granted requester sees ready=1; ready is 0 outside IDLE and while RESET is low. On handshake: latch id, write flag, addr, wdata; update last_grant; -> CMD.
- CMD (1 cycle): c2_oe=1, c2_out=READ_LINE/WRITE_LINE, a2=addr. Write: d2_oe=1, d2_out=beat 0, -> WDATA. Read: d2_oe=0, -> WAIT_RSP.
- WDATA: beats 1..7 on consecutive cycles, c2_oe=1 with c2_out=NOP, d2_oe=1; after beat 7 -> WAIT_RSP.
- WAIT_RSP: all oe=0. c2_in==RESPONSE: write -> DONE; read -> capture d2_in as beat 0, -> RDATA. Other c2_in values ignored. Watchdog counts WAIT_RSP cycles from 0; if no response by count TIMEOUT-1 -> DONE with err. A response on that same cycle wins.
- RDATA: capture beats 1..7 on 7 consecutive cycles, -> DONE.
- DONE (1 cycle): rsp_valid=1 with rsp_id, rsp_err; rsp_rdata = assembled line for reads without error, else holds its previous value. -> IDLE.
- rsp_id/rsp_err/rsp_rdata hold after DONE until the next DONE.
- Beat counter: 3 bits, wraps 7->0, reset at CMD.

## Timing
- Reset (async assert): state IDLE, last_grant=1, all oe=0, c2_out=0, a2=0, d2_out=0, rsp_valid=0, rsp_id=0, rsp_err=0, rsp_rdata=0, busy=0, ready=0. Outputs take these values immediately on assertion. A transfer in flight is abandoned with no rsp_valid.
- Handshake at cycle T -> CMD at T+1.
- Write: D2 beats at T+1..T+8; WAIT_RSP from T+9; response at R -> rsp_valid at R+1.
- Read: WAIT_RSP from T+2; response (with beat 0) at R; beats 1..7 at R+1..R+7; rsp_valid at R+8.
- Next handshake is possible at the cycle after DONE. Requests raised while busy wait with ready=0 and must hold valid and fields stable.
- Minimum bus release: oe drops on the first WAIT_RSP cycle. Memory must not drive before that cycle.

## Test plan
- Write from req0, addr 0x1A5, wdata bytes 0x00..0x0F -> CMD beat C2=3, A2=0x1A5, D2=0x0100; beats 0x0302..0x0F0E; RESPONSE 3 cycles later -> rsp_valid, id=0, err=0.
- Read from req1, addr 0x7FFF; memory responds 5 cycles after release with beats 0xBBAA, ... -> rsp_rdata[15:0]=0xBBAA, rsp_valid 8 cycles after response, id=1.
- Both requesters valid from reset -> grants 0,1,0,1 over four back-to-back transfers; non-granted ready stays 0.
- No response to a read -> rsp_valid with err=1 after exactly TIMEOUT WAIT_RSP cycles; response on the final cycle -> err=0.
- RESET low during WDATA beat 4 -> c2_oe=d2_oe=0 immediately, no rsp_valid; after release, req0 (last_grant=1) wins a tie.
- C2=2 noise on c2_in during WAIT_RSP -> ignored, transfer completes on the later RESPONSE.

Source files
------------

// File: rtl/c2_line_sequencer.sv
// c2_line_sequencer
// Arbitrates two line-transfer requesters onto the shared C2/D2/A2 bus and
// sequences each transfer. A transfer is a command beat, then the write data beats
// (writes only), then a response wait under a watchdog, then the read data beats
// (reads only), then a one-cycle completion pulse.
//
// Ports
//   clk, RESET                    clock (rising edge), async active-low reset
//   reqN_valid/ready              request handshake, N = 0,1 (round-robin grant)
//   reqN_write/addr/wdata         transfer kind, line address, write line
//   c2_out/c2_oe/c2_in            command pins, split for an external tristate
//   a2                            line address, nonzero only in the command beat
//   d2_out/d2_oe/d2_in            data pins, split for an external tristate
//   rsp_valid/id/err/rdata        completion pulse plus held result fields
//   busy                          transfer in progress
module c2_line_sequencer #(
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned BUS_W      = 16,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic                    req0_write,
    input  logic [ADDR_W-1:0]       req0_addr,
    input  logic [LINE_BYTES*8-1:0] req0_wdata,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic                    req1_write,
    input  logic [ADDR_W-1:0]       req1_addr,
    input  logic [LINE_BYTES*8-1:0] req1_wdata,
    output logic [1:0]              c2_out,
    output logic                    c2_oe,
    input  logic [1:0]              c2_in,
    output logic [ADDR_W-1:0]       a2,
    output logic [BUS_W-1:0]        d2_out,
    output logic                    d2_oe,
    input  logic [BUS_W-1:0]        d2_in,
    output logic                    rsp_valid,
    output logic                    rsp_id,
    output logic                    rsp_err,
    output logic [LINE_BYTES*8-1:0] rsp_rdata,
    output logic                    busy
);

    localparam int unsigned LineW = LINE_BYTES * 8;
    localparam int unsigned Beats = LineW / BUS_W;
    localparam int unsigned BeatW = $clog2(Beats);
    localparam int unsigned WdW   = $clog2(TIMEOUT + 1);

    localparam logic [1:0] C2Nop       = 2'd0;
    localparam logic [1:0] C2Response  = 2'd1;
    localparam logic [1:0] C2ReadLine  = 2'd2;
    localparam logic [1:0] C2WriteLine = 2'd3;

    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
    localparam logic [WdW-1:0]   WdLast   = WdW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StWaitRsp,
        StRdata,
        StDone
    } state_e;

    state_e             state_q;
    logic               last_grant_q;
    logic               id_q;
    logic               write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LineW-1:0]   wdata_q;
    logic [BeatW-1:0]   beat_q;
    logic [WdW-1:0]     wd_q;
    // The last read beat goes straight into rsp_rdata, so only beats 0..Beats-2 are
    // buffered here.
    logic [LineW-BUS_W-1:0] rbuf_q;
    logic               rsp_id_q;
    logic               rsp_err_q;
    logic [LineW-1:0]   rsp_rdata_q;

    logic grant0;
    logic grant1;

    // Round robin. On a tie the requester that was not granted last time wins.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    assign req0_ready = RESET & (state_q == StIdle) & grant0;
    assign req1_ready = RESET & (state_q == StIdle) & grant1;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            beat_q       <= '0;
            wd_q         <= '0;
            rbuf_q       <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant0 || grant1) begin
                        id_q         <= grant1;
                        write_q      <= grant1 ? req1_write : req0_write;
                        addr_q       <= grant1 ? req1_addr : req0_addr;
                        wdata_q      <= grant1 ? req1_wdata : req0_wdata;
                        last_grant_q <= grant1;
                        beat_q       <= '0;
                        state_q      <= StCmd;
                    end
                end
                StCmd: begin
                    wd_q <= '0;
                    if (write_q) begin
                        // Beat 0 is driven alongside the command.
                        beat_q  <= beat_q + 1'b1;
                        state_q <= StWdata;
                    end else begin
                        beat_q  <= '0;
                        state_q <= StWaitRsp;
                    end
                end
                StWdata: begin
                    // The counter wraps to 0 after the last beat, ready for a read capture.
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_q <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    // A response beats the watchdog when both happen in the same cycle.
                    if (c2_in == C2Response) begin
                        if (write_q) begin
                            rsp_id_q  <= id_q;
                            rsp_err_q <= 1'b0;
                            state_q   <= StDone;
                        end else begin
                            rbuf_q[BUS_W-1:0] <= d2_in;
                            beat_q            <= beat_q + 1'b1;
                            state_q           <= StRdata;
                        end
                    end else if (wd_q == WdLast) begin
                        rsp_id_q  <= id_q;
                        rsp_err_q <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StRdata: begin
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        rsp_rdata_q <= {d2_in, rbuf_q};
                        rsp_id_q    <= id_q;
                        rsp_err_q   <= 1'b0;
                        state_q     <= StDone;
                    end else begin
                        rbuf_q[int'(beat_q) * BUS_W +: BUS_W] <= d2_in;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Bus outputs are decoded from registered state only, so the async reset clears
    // them at once.
    assign busy      = (state_q != StIdle);
    assign c2_oe     = (state_q == StCmd) | (state_q == StWdata);
    assign c2_out    = (state_q == StCmd) ? (write_q ? C2WriteLine : C2ReadLine) : C2Nop;
    assign a2        = (state_q == StCmd) ? addr_q : '0;
    assign d2_oe     = ((state_q == StCmd) & write_q) | (state_q == StWdata);
    assign d2_out    = d2_oe ? wdata_q[int'(beat_q) * BUS_W +: BUS_W] : '0;
    assign rsp_valid = (state_q == StDone);
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_c2_line_sequencer.sv
// Directed testbench for c2_line_sequencer. It covers a write, a read, command
// noise on C2, the watchdog, a reset in mid-transfer, and round-robin arbitration.
module tb_c2_line_sequencer;

    logic         clk;
    logic         RESET;
    logic         req0_valid, req0_ready, req0_write;
    logic [14:0]  req0_addr;
    logic [127:0] req0_wdata;
    logic         req1_valid, req1_ready, req1_write;
    logic [14:0]  req1_addr;
    logic [127:0] req1_wdata;
    logic [1:0]   c2_out, c2_in;
    logic         c2_oe;
    logic [14:0]  a2;
    logic [15:0]  d2_out, d2_in;
    logic         d2_oe;
    logic         rsp_valid, rsp_id, rsp_err;
    logic [127:0] rsp_rdata;
    logic         busy;

    int errors = 0;
    int checks = 0;

    c2_line_sequencer dut (
        .clk        (clk),
        .RESET      (RESET),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .c2_out     (c2_out),
        .c2_oe      (c2_oe),
        .c2_in      (c2_in),
        .a2         (a2),
        .d2_out     (d2_out),
        .d2_oe      (d2_oe),
        .d2_in      (d2_in),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Both requesters are held valid with writes; the grant goes to exp_id.
    task automatic run_write(input logic exp_id, input logic [14:0] exp_addr);
        check("rr_ready_granted", exp_id ? req1_ready : req0_ready, 1'b1);
        check("rr_ready_other", exp_id ? req0_ready : req1_ready, 1'b0);
        tick();
        check("rr_cmd", c2_out, 2'd3);
        check("rr_a2", a2, exp_addr);
        for (int i = 0; i < 8; i++) begin
            check("rr_busy_ready", {req0_ready, req1_ready}, 2'b00);
            tick();
        end
        c2_in = 2'd1;
        tick();
        c2_in = 2'd0;
        check("rr_rsp_valid", rsp_valid, 1'b1);
        check("rr_rsp_id", rsp_id, exp_id);
        tick();
    endtask

    logic [127:0] line_rd;
    logic [127:0] line_rd2;
    logic [15:0]  bv;
    int           n;

    initial begin
        RESET = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        c2_in = 2'd0; d2_in = '0;

        // Reset state.
        #12;
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_outputs", {c2_oe, d2_oe, c2_out, a2, d2_out}, '0);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_err, busy}, 4'b0000);
        check("rst_rdata", rsp_rdata, '0);
        req0_valid = 1'b0;
        tick();
        RESET = 1'b1;
        tick();

        // Write from req0: addr 0x1A5, bytes 0x00..0x0F.
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 15'h1A5;
        req0_wdata = 128'h0F0E0D0C0B0A09080706050403020100;
        #1;
        check("w_ready0", req0_ready, 1'b1);
        check("w_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        check("w_cmd_c2", {c2_oe, c2_out}, 3'b111);
        check("w_cmd_a2", a2, 15'h1A5);
        check("w_cmd_d2", {d2_oe, d2_out}, {1'b1, 16'h0100});
        check("w_cmd_busy", busy, 1'b1);
        for (int k = 1; k < 8; k++) begin
            tick();
            bv = {8'(2 * k + 1), 8'(2 * k)};
            check("w_beat_d2", {d2_oe, d2_out}, {1'b1, bv});
            check("w_beat_c2", {c2_oe, c2_out}, 3'b100);
        end
        tick();
        check("w_release", {c2_oe, d2_oe}, 2'b00);
        tick();
        tick();
        check("w_wait_norsp", rsp_valid, 1'b0);
        c2_in = 2'd1;
        tick();
        c2_in = 2'd0;
        check("w_done", {rsp_valid, rsp_id, rsp_err}, 3'b100);
        tick();
        check("w_after_done", {rsp_valid, busy}, 2'b00);

        // Read from req1 at 0x7FFF with C2=2 noise before a response five cycles
        // after release.
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 15'h7FFF;
        #1;
        check("r_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        check("r_cmd", {c2_oe, c2_out, d2_oe}, 4'b1100);
        check("r_cmd_a2", a2, 15'h7FFF);
        tick();
        check("r_release", {c2_oe, d2_oe}, 2'b00);
        for (int i = 0; i < 5; i++) begin
            c2_in = (i == 2) ? 2'd2 : 2'd0;
            check("r_wait", {rsp_valid, busy}, 2'b01);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            bv = 16'hBBAA + 16'(k) * 16'h0101;
            line_rd[k * 16 +: 16] = bv;
            c2_in = (k == 0) ? 2'd1 : 2'd0;
            d2_in = bv;
            if (k > 0) check("r_beats_novalid", rsp_valid, 1'b0);
            tick();
        end
        c2_in = 2'd0;
        check("r_done", {rsp_valid, rsp_id, rsp_err}, 3'b110);
        check("r_rdata", rsp_rdata, line_rd);
        check("r_rdata_b0", rsp_rdata[15:0], 16'hBBAA);
        tick();
        check("r_hold", {rsp_valid, rsp_id}, 2'b01);

        // Read with no response: the watchdog fires after 255 WAIT_RSP cycles.
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 15'h0055;
        tick();
        req0_valid = 1'b0;
        tick();
        n = 0;
        while (rsp_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("to_cycles", n, 255);
        check("to_done", {rsp_valid, rsp_id, rsp_err}, 3'b101);
        check("to_rdata_held", rsp_rdata, line_rd);
        tick();

        // Response on the last watchdog cycle wins over the timeout.
        req0_valid = 1'b1; req0_addr = 15'h0066;
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 254; i++) tick();
        check("tl_still_wait", {rsp_valid, busy}, 2'b01);
        for (int k = 0; k < 8; k++) begin
            bv = 16'h1000 + 16'(k) * 16'h0202;
            line_rd2[k * 16 +: 16] = bv;
            c2_in = (k == 0) ? 2'd1 : 2'd0;
            d2_in = bv;
            tick();
            if (k == 0) check("tl_no_timeout", rsp_valid, 1'b0);
        end
        c2_in = 2'd0;
        check("tl_done", {rsp_valid, rsp_id, rsp_err}, 3'b100);
        check("tl_rdata", rsp_rdata, line_rd2);
        tick();

        // Reset in the middle of a write from req1, during beat 4.
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 15'h0123;
        req1_wdata = 128'hFEDCBA98765432100123456789ABCDEF;
        #1;
        check("rw_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rw_beat4", {d2_oe, d2_out}, {1'b1, 16'h3210});
        #2;
        RESET = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("rw_oe_cleared", {c2_oe, d2_oe}, 2'b00);
        check("rw_outputs_cleared", {c2_out, a2, d2_out}, '0);
        check("rw_rsp_cleared", {rsp_valid, rsp_err, busy, req0_ready}, 4'b0000);
        check("rw_rdata_cleared", rsp_rdata, '0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rw_in_reset", {rsp_valid, req0_ready}, 2'b00);
        end
        RESET = 1'b1;

        // Round robin from reset, with both requesters held valid.
        req0_write = 1'b1; req0_addr = 15'h01A5;
        req1_write = 1'b1; req1_addr = 15'h0222;
        req1_valid = 1'b1;
        #1;
        run_write(1'b0, 15'h01A5);
        run_write(1'b1, 15'h0222);
        run_write(1'b0, 15'h01A5);
        run_write(1'b1, 15'h0222);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("end_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
